// File: rtl/gf2_div_pkg.sv
// Shared types and defaults for the GF(2)[x] long divider.
// Polynomials are bit vectors with bit i holding the coefficient of x^i.
package gf2_div_pkg;

   localparam int DW_DEF = 15;
   localparam int VW_DEF = 9;
   localparam logic [8:0] AES_POLY = 9'h11B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // A down-counter must hold QW-1; keep at least one bit for degenerate widths.
   function automatic int cnt_width(input int qw);
      return (qw > 1) ? $clog2(qw) : 1;
   endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One long-division step: examines bit cnt+VW-1 of the running remainder and
// cancels it with the divisor aligned at cnt. Purely combinational.
module gf2_div_step
   import gf2_div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF,
   parameter int CW = 3
) (
   input  logic [DW-1:0] rem,
   input  logic [VW-1:0] div,
   input  logic [CW-1:0] cnt,
   output logic [DW-1:0] rem_nxt,
   output logic          q_bit
);

   logic [DW-1:0] div_ext;
   logic [DW-1:0] rem_sh;

   always_comb begin
      div_ext = DW'(div);
      // Shifting the remainder down puts the examined coefficient at VW-1.
      rem_sh  = rem >> cnt;
      q_bit   = rem_sh[VW-1];
      rem_nxt = q_bit ? (rem ^ (div_ext << cnt)) : rem;
   end

endmodule

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2)[x] divider, one quotient bit per clock: result QW+1 edges after
// accept (1 edge for a non-monic divisor); result held in DONE until out_ready.
module gf2_poly_divider
   import gf2_div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DW-1:0]       dividend,
   input  logic [VW-1:0]       divisor,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DW-VW:0]      quotient,
   output logic [VW-2:0]       remainder,
   output logic                err,
   output logic                busy
);

   localparam int QW = DW - VW + 1;
   localparam int CW = cnt_width(QW);

   state_t          state_q;
   state_t          state_d;
   logic [DW-1:0]   rem_r;
   logic [VW-1:0]   div_r;
   logic [QW-1:0]   q_r;
   logic [CW-1:0]   cnt_r;
   logic            err_r;

   logic [DW-1:0]   step_rem;
   logic            step_q;

   gf2_div_step #(
      .DW (DW),
      .VW (VW),
      .CW (CW)
   ) u_step (
      .rem     (rem_r),
      .div     (div_r),
      .cnt     (cnt_r),
      .rem_nxt (step_rem),
      .q_bit   (step_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // A non-monic divisor skips the division entirely.
               state_d = divisor[VW-1] ? BUSY : DONE;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (cnt_r == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_r <= '0;
         div_r <= '0;
         q_r   <= '0;
         cnt_r <= '0;
         err_r <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  rem_r <= dividend;
                  div_r <= divisor;
                  q_r   <= '0;
                  cnt_r <= CW'(QW - 1);
                  err_r <= ~divisor[VW-1];
               end
            end
            BUSY: begin
               rem_r        <= step_rem;
               q_r[cnt_r]   <= step_q;
               if (cnt_r != '0) begin
                  cnt_r <= cnt_r - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Results stay visible after the hand-off until the next operation is accepted.
   assign quotient  = q_r;
   assign remainder = rem_r[VW-2:0];
   assign err       = err_r;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Randomized bench for gf2_poly_divider against a polynomial long-division model.
module tb_gf2_poly_divider;

   localparam int DW = 15;
   localparam int VW = 9;
   localparam int QW = DW - VW + 1;
   localparam int TMO = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] quotient;
   logic [VW-2:0] remainder;
   logic          err;
   logic          busy;

   int n_chk  = 0;
   int n_pass = 0;

   gf2_poly_divider #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int degree(input logic [31:0] p);
      int d = -1;
      for (int i = 0; i < 32; i++) begin
         if (p[i]) d = i;
      end
      return d;
   endfunction

   // Textbook division: repeatedly cancel the leading term until deg(r) < deg(b).
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      int db = degree(b);
      int dr;
      q = 0;
      r = a;
      dr = degree(r);
      while (dr >= db) begin
         q = q | (32'd1 << (dr - db));
         r = r ^ (b << (dr - db));
         dr = degree(r);
      end
   endfunction

   function automatic logic [31:0] clmul(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] p = 0;
      for (int i = 0; i < 16; i++) begin
         if (a[i]) p = p ^ (b << i);
      end
      return p;
   endfunction

   // Presents one operation and counts edges, the accepting edge included, until out_valid.
   task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < TMO) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [31:0] eq, er;
      logic [QW-1:0] hold_q;
      logic [VW-2:0] hold_r;

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      dividend = '0;
      divisor = '0;
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;

      // AES product reduced by the field polynomial
      do_op(15'h2B79, 9'h11B, lat);
      check("aes_latency", 32'(lat), 32'd8);
      check("aes_quotient", 32'(quotient), 32'h28);
      check("aes_remainder", 32'(remainder), 32'hC1);
      check("aes_err", 32'(err), 32'd0);

      // Backpressure in DONE while the input side is noisy
      hold_q = quotient;
      hold_r = remainder;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom);
         dividend = DW'($urandom);
         divisor  = VW'($urandom);
         @(posedge clk); #1;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_quotient", 32'(quotient), 32'h28);
         check("bp_remainder", 32'(remainder), 32'hC1);
      end
      in_valid = 1'b0;
      release_result();
      check("bp_rel_out_valid", 32'(out_valid), 32'd0);
      check("bp_rel_in_ready", 32'(in_ready), 32'd1);
      check("bp_rel_hold_q", 32'(quotient), 32'(hold_q));
      check("bp_rel_hold_r", 32'(remainder), 32'(hold_r));

      // Non-monic divisor
      do_op(15'h1234, 9'h0FF, lat);
      check("nm_latency", 32'(lat), 32'd1);
      check("nm_err", 32'(err), 32'd1);
      check("nm_busy", 32'(busy), 32'd0);
      check("nm_quotient", 32'(quotient), 32'd0);
      check("nm_remainder", 32'(remainder), 32'h34);
      release_result();

      // Reset while busy
      dividend = 15'h2B79;
      divisor  = 9'h11B;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_quotient", 32'(quotient), 32'd0);
      check("mid_rst_remainder", 32'(remainder), 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      do_op(15'h00C1, 9'h11B, lat);
      check("post_rst_latency", 32'(lat), 32'd8);
      check("post_rst_quotient", 32'(quotient), 32'd0);
      check("post_rst_remainder", 32'(remainder), 32'hC1);
      release_result();

      // Monomial divisor and zero dividend
      do_op(15'h7FFF, 9'h100, lat);
      check("mono_quotient", 32'(quotient), 32'h7F);
      check("mono_remainder", 32'(remainder), 32'hFF);
      release_result();
      do_op(15'h0000, 9'h11B, lat);
      check("zero_quotient", 32'(quotient), 32'd0);
      check("zero_remainder", 32'(remainder), 32'd0);
      release_result();

      for (int n = 0; n < 1000; n++) begin
         logic [DW-1:0] a;
         logic [VW-1:0] b;
         a = DW'($urandom);
         if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(1, 14);
         b = {1'b1, 8'($urandom)};
         check("rnd_in_ready", 32'(in_ready), 32'd1);
         do_op(a, b, lat);
         ref_div(32'(a), 32'(b), eq, er);
         check("rnd_latency", 32'(lat), 32'd8);
         check("rnd_quotient", 32'(quotient), eq);
         check("rnd_remainder", 32'(remainder), er);
         check("rnd_invariant", clmul(32'(quotient), 32'(b)) ^ 32'(remainder), 32'(a));
         release_result();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/gf2_poly_divider.md
Name: gf2_poly_divider

Overview:
- Sequential GF(2)[x] long divider; the inverse direction of the carry-less partial-product multipliers in this codebase.
- Takes a raw carry-less product (up to 15 bits for 8x8 operands) and a monic divisor polynomial.
- Returns quotient and remainder, one quotient bit per clock.
- Used after the combinational multipliers to reduce products modulo a field polynomial (e.g. 0x11B), and standalone to verify them.

Parameters:
- DW, 15, dividend width in bits (degree DW-1).
- VW, 9, divisor width in bits (degree VW-1); VW <= DW required.
- QW, DW-VW+1 (=7), derived quotient width; not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  DW  polynomial coefficients, bit i = x^i.
- divisor  input  VW  polynomial; bit VW-1 must be 1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  QW  quotient coefficients.
- remainder  output  VW-1  remainder coefficients (degree < VW-1).
- err  output  1  divisor was not monic (bit VW-1 = 0).
- busy  output  1  high in BUSY state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, err=0, quotient=0, remainder=0, internal registers 0.
- An assertion of rst mid-operation aborts the operation immediately. No partial result is emitted.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, capture dividend into rem_r (DW bits) and divisor into div_r; clear q_r; set cnt=QW-1.
  - If divisor[VW-1]==0: go to DONE with err=1, quotient=0, remainder=dividend[VW-2:0]. No BUSY cycles.
  - Otherwise go to BUSY.
- BUSY (in_ready=0, busy=1): each edge processes bit position i = cnt+VW-1.
  - If rem_r[i]==1: q_r[cnt]=1 and rem_r ^= div_r << cnt. Else q_r[cnt]=0.
  - When cnt==0, go to DONE; else cnt decrements.
  - Exactly QW BUSY edges are spent.
- DONE:
  - out_valid=1; quotient=q_r, remainder=rem_r[VW-2:0], err as captured.
  - Outputs are held stable while out_ready=0.
  - On out_ready at an edge: go to IDLE, out_valid=0. quotient/remainder/err keep their last values until the next accept.
- Latency: out_valid rises QW+1 edges after the accepting edge (8 for defaults), or 1 edge for err.
- Throughput: one operation per QW+2 cycles minimum.
- in_ready is low in BUSY and DONE. in_valid there is ignored, and dividend/divisor may change freely.
- Arithmetic is pure XOR. No carries, no width growth.
- Boundary cases:
  - dividend=0 gives quotient=0, remainder=0.
  - dividend degree < VW-1 gives quotient=0, remainder=dividend.
  - divisor==1<<(VW-1) (monomial) gives remainder=dividend[VW-2:0], quotient=dividend[DW-1:VW-1].
- Invariant: clmul(quotient, divisor) ^ remainder == dividend whenever err=0.

Decomposition:
- Package gf2_div_pkg:
  - state enum {IDLE, BUSY, DONE};
  - default widths DW_DEF=15, VW_DEF=9;
  - constant AES_POLY=9'h11B.
- One natural sub-module: gf2_div_step. Combinational; inputs rem (DW), div (VW), cnt. Outputs next rem and the quotient bit.
- The top-level holds the FSM, counter and handshake registers.

Test Plan:
- AES reference: dividend=15'h2B79 (clmul 0x57*0x83), divisor=9'h11B -> quotient=7'h28, remainder=8'hC1, err=0; out_valid exactly 8 edges after accept.
- Non-monic divisor: dividend=15'h1234, divisor=9'h0FF -> err=1, quotient=0, remainder=8'h34, out_valid 1 edge after accept, no BUSY.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid/dividend -> outputs stable, in_ready=0, no new capture; then out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Reset mid-BUSY: assert rst 3 cycles after accept -> out_valid=0, in_ready=1, quotient=0, remainder=0 immediately (asynchronously). The next operation (15'h00C1 / 9'h11B) -> quotient=0, remainder=8'hC1.
- Edge values:
  - dividend=15'h7FFF, divisor=9'h100 -> quotient=7'h7F, remainder=8'hFF.
  - dividend=0 -> quotient=0, remainder=0.
- Random: 1000 ops with random monic divisors and random dividends, checking the invariant clmul(quotient, divisor) ^ remainder == dividend against a reference model.
